// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: reset PC, bubble encoding, instruction width and fetch FSM states.
// Pure constants and types; no logic and no latency.
// No handshaking here.
package pipeline_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0]        RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch stage bundle: hazard-unit controls, instruction-memory req/ack port and the IF/ID outputs.
// No latency; this is wiring only.
// The master side is the fetch unit; the slave side holds the hazard unit, memory and IF/ID.
interface if_fetch_unit_if;
    import pipeline_pkg::*;

    logic               stall_i;
    logic               branch_i;
    logic [31:0]        branch_target_i;
    logic               imem_req_o;
    logic [31:0]        imem_addr_o;
    logic               imem_ack_i;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic [31:0]        npc_o;
    logic [INSTR_W-1:0] instruction_o;

    modport master (
        input  stall_i, branch_i, branch_target_i, imem_ack_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, npc_o, instruction_o
    );

    modport slave (
        output stall_i, branch_i, branch_target_i, imem_ack_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, npc_o, instruction_o
    );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues imem requests, presents instruction + PC+4 to IF/ID.
// Zero-cycle fetch-to-IF/ID latency: the acked word is presented combinationally in the ack cycle.
// A stall parks the acked word in HOLD (no request); a redirect over a pending request drains it in DROP.
module if_fetch_unit
    import pipeline_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    if_fetch_unit_if.master fb
);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        redir_q, redir_d;
    logic [INSTR_W-1:0] hold_q, hold_d;

    logic [31:0]        pc_inc;
    logic [31:0]        target;

    assign pc_inc = pc_q + 32'd4;
    assign target = {fb.branch_target_i[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        hold_d  = hold_q;
        case (state_q)
            FETCH: begin
                if (fb.branch_i) begin
                    if (fb.imem_ack_i) begin
                        pc_d = target;
                    end else begin
                        // Request already on the bus must complete before the target is fetched.
                        redir_d = target;
                        state_d = DROP;
                    end
                end else if (fb.imem_ack_i) begin
                    if (fb.stall_i) begin
                        hold_d  = fb.imem_rdata_i;
                        state_d = HOLD;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            HOLD: begin
                if (fb.branch_i) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!fb.stall_i) begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (fb.imem_ack_i) begin
                    pc_d    = fb.branch_i ? target : redir_q;
                    state_d = FETCH;
                end else if (fb.branch_i) begin
                    redir_d = target;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        fb.instruction_o = NOP_INSTR;
        fb.npc_o         = 32'd0;
        if (!rst_i && !fb.branch_i) begin
            if (state_q == FETCH && fb.imem_ack_i) begin
                fb.instruction_o = fb.imem_rdata_i;
                fb.npc_o         = pc_inc;
            end else if (state_q == HOLD) begin
                fb.instruction_o = hold_q;
                fb.npc_o         = pc_inc;
            end
        end
    end

    assign fb.imem_req_o  = !rst_i && (state_q != HOLD);
    assign fb.imem_addr_o = pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            redir_q <= 32'd0;
            hold_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed memory/hazard stimulus, a behavioural fetch model checked every
// cycle, and literal expectations at the notable points of each scenario.
module tb_if_fetch_unit;
    import pipeline_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    if_fetch_unit_if fb();

    if_fetch_unit dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .fb    (fb.master)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural view: where the PC points, whether a stalled word is parked,
    // and whether a redirect is waiting for an in-flight request to return.
    logic [31:0] m_pc       = RESET_PC;
    bit          m_parked   = 1'b0;
    logic [31:0] m_park_wd  = NOP_INSTR;
    bit          m_draining = 1'b0;
    logic [31:0] m_redir    = 32'd0;

    logic [31:0] e_req, e_addr, e_npc, e_instr, tgt_al;

    always @(negedge clk_i) begin
        tgt_al  = {fb.branch_target_i[31:2], 2'b00};
        e_req   = 32'(!rst_i && !m_parked);
        e_addr  = rst_i ? RESET_PC : m_pc;
        e_npc   = 32'd0;
        e_instr = NOP_INSTR;
        if (!rst_i && !fb.branch_i) begin
            if (m_parked) begin
                e_instr = m_park_wd;
                e_npc   = m_pc + 32'd4;
            end else if (!m_draining && fb.imem_ack_i) begin
                e_instr = fb.imem_rdata_i;
                e_npc   = m_pc + 32'd4;
            end
        end
        chk("model_req",   32'(fb.imem_req_o), e_req);
        chk("model_addr",  fb.imem_addr_o,     e_addr);
        chk("model_npc",   fb.npc_o,           e_npc);
        chk("model_instr", fb.instruction_o,   e_instr);
    end

    always @(posedge clk_i) begin
        tgt_al = {fb.branch_target_i[31:2], 2'b00};
        if (rst_i) begin
            m_pc = RESET_PC; m_parked = 0; m_draining = 0; m_park_wd = NOP_INSTR; m_redir = 0;
        end else if (m_parked) begin
            if (fb.branch_i)     begin m_pc = tgt_al;       m_parked = 0; end
            else if (!fb.stall_i) begin m_pc = m_pc + 32'd4; m_parked = 0; end
        end else if (m_draining) begin
            if (fb.imem_ack_i) begin
                m_pc = fb.branch_i ? tgt_al : m_redir;
                m_draining = 0;
            end else if (fb.branch_i) begin
                m_redir = tgt_al;
            end
        end else if (fb.branch_i) begin
            if (fb.imem_ack_i) m_pc = tgt_al;
            else begin m_redir = tgt_al; m_draining = 1; end
        end else if (fb.imem_ack_i) begin
            if (fb.stall_i) begin m_park_wd = fb.imem_rdata_i; m_parked = 1; end
            else m_pc = m_pc + 32'd4;
        end
    end

    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic a, input logic [31:0] d);
        @(posedge clk_i);
        #1;
        rst_i              = r;
        fb.stall_i         = s;
        fb.branch_i        = b;
        fb.branch_target_i = t;
        fb.imem_ack_i      = a;
        fb.imem_rdata_i    = d;
        #2;
    endtask

    task automatic lit(input string nm, input logic req, input logic [31:0] addr,
                       input logic [31:0] npc, input logic [31:0] instr);
        chk({nm, "_req"},   32'(fb.imem_req_o), 32'(req));
        chk({nm, "_addr"},  fb.imem_addr_o,     addr);
        chk({nm, "_npc"},   fb.npc_o,           npc);
        chk({nm, "_instr"}, fb.instruction_o,   instr);
    endtask

    logic [31:0] words [4];

    initial begin
        words[0] = 32'h0010_0093; words[1] = 32'h0020_0113;
        words[2] = 32'h0030_0193; words[3] = 32'h0040_0213;
        fb.stall_i = 0; fb.branch_i = 0; fb.branch_target_i = 0;
        fb.imem_ack_i = 0; fb.imem_rdata_i = 0;
        #2;
        lit("reset", 1'b0, 32'h0, 32'h0, NOP_INSTR);

        // Zero-wait memory straight out of reset.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, words[i]);
            lit("stream", 1'b1, 32'(4 * i), 32'(4 * i + 4), words[i]);
        end

        // Two-cycle memory latency at 0x10.
        cyc(0, 0, 0, 0, 0, 0);   lit("wait0", 1'b1, 32'h10, 32'h0, NOP_INSTR);
        cyc(0, 0, 0, 0, 0, 0);   lit("wait1", 1'b1, 32'h10, 32'h0, NOP_INSTR);
        cyc(0, 0, 0, 0, 1, 32'hAAAA_0001); lit("wait_ack", 1'b1, 32'h10, 32'h14, 32'hAAAA_0001);

        // Ack under stall, held for three cycles.
        cyc(0, 1, 0, 0, 1, 32'h5555_1234); lit("stall_ack", 1'b1, 32'h14, 32'h18, 32'h5555_1234);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            lit("hold", 1'b0, 32'h14, 32'h18, 32'h5555_1234);
        end
        cyc(0, 0, 0, 0, 0, 0);   lit("hold_release", 1'b0, 32'h14, 32'h18, 32'h5555_1234);
        cyc(0, 0, 0, 0, 0, 0);   lit("resume", 1'b1, 32'h18, 32'h0, NOP_INSTR);

        // Redirect to an unaligned target while a request is outstanding.
        cyc(0, 0, 1, 32'h103, 0, 0);        lit("br_pend", 1'b1, 32'h18, 32'h0, NOP_INSTR);
        cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);  lit("drop_ack", 1'b1, 32'h18, 32'h0, NOP_INSTR);
        cyc(0, 0, 0, 0, 1, 32'h1111_2222);  lit("at_target", 1'b1, 32'h100, 32'h104, 32'h1111_2222);

        // Several redirects while draining: the last one wins.
        cyc(0, 0, 1, 32'h1F0, 0, 0);
        cyc(0, 0, 1, 32'h200, 0, 0);        lit("drop_br2", 1'b1, 32'h104, 32'h0, NOP_INSTR);
        cyc(0, 0, 1, 32'h300, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hBAD0_BAD0);  lit("drop_ack2", 1'b1, 32'h104, 32'h0, NOP_INSTR);
        cyc(0, 0, 0, 0, 0, 0);              lit("latest_wins", 1'b1, 32'h300, 32'h0, NOP_INSTR);

        // Branch coincident with an ack jumps straight to the top of memory, then wraps.
        cyc(0, 0, 1, 32'hFFFF_FFFE, 1, 32'hBAD1_BAD1); lit("br_ack", 1'b1, 32'h300, 32'h0, NOP_INSTR);
        cyc(0, 0, 0, 0, 1, 32'h7777_0000);  lit("wrap_ack", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h7777_0000);
        cyc(0, 1, 0, 0, 1, 32'h7777_0004);  lit("wrapped", 1'b1, 32'h0, 32'h4, 32'h7777_0004);

        // Branch and stall together in HOLD: branch wins.
        cyc(0, 1, 1, 32'h43, 0, 0);         lit("br_over_stall", 1'b0, 32'h0, 32'h0, NOP_INSTR);
        cyc(0, 0, 0, 0, 0, 0);              lit("br_hold_tgt", 1'b1, 32'h40, 32'h0, NOP_INSTR);

        // Reset asserted while draining a redirect.
        cyc(0, 0, 1, 32'h80, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);              lit("rst_drop", 1'b0, RESET_PC, 32'h0, NOP_INSTR);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h9999_0000);  lit("post_rst", 1'b1, RESET_PC, 32'h4, 32'h9999_0000);
        cyc(0, 0, 0, 0, 0, 0);

        @(posedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
